// File: rtl/bus_initiator_if.sv
// rtl/bus_initiator_if.sv - controller-side request/response handshake for bus_initiator
interface bus_initiator_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddress;
    logic [DATA_W-1:0] ReqData;
    logic              RspValid;
    logic [DATA_W-1:0] RspData;
    logic              Busy;

    // Controller side: issues requests, observes responses
    modport master (
        output ReqValid, ReqWrite, ReqAddress, ReqData,
        input  ReqReady, RspValid, RspData, Busy
    );

    // Initiator side: accepts requests, produces responses
    modport slave (
        input  ReqValid, ReqWrite, ReqAddress, ReqData,
        output ReqReady, RspValid, RspData, Busy
    );
endinterface

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - queued register-bus initiator producing one strobed cycle per request
module bus_initiator #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int CLK_HIGH   = 1,
    parameter int CLK_LOW    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    bus_initiator_if.slave    ctl,
    output logic [ADDR_W-1:0] BusAddress,
    inout  wire  [DATA_W-1:0] BusData,
    output logic              BusReadWrite,
    output logic              BusClock
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (CLK_HIGH > CLK_LOW) ? CLK_HIGH : CLK_LOW;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Request queue
    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q, count_d;
    logic               ready_q;
    logic               full, empty, push, pop;
    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    // Transaction engine
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               rw_q, rw_d;
    logic               clk_q, clk_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // ready_q keeps ReqReady low through reset and raises it the cycle after release
    assign ctl.ReqReady = Reset & ready_q & ~full;
    assign push  = ctl.ReqValid & ctl.ReqReady;
    assign {head_write, head_addr, head_data} = fifo_mem_q[rd_ptr_q];

    // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Queue storage and pointers; entry contents need no reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            count_q <= count_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {ctl.ReqWrite, ctl.ReqAddress, ctl.ReqData};
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Next-state and next-output logic; bus outputs are all registered from these
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw_d        = rw_q;
        clk_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                rw_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    addr_d  = head_addr;
                    data_d  = head_data;
                    rw_d    = head_write;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                clk_d   = 1'b1;
                cnt_d   = CNT_W'(CLK_HIGH - 1);
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(CLK_LOW - 1);
                    state_d = HOLD;
                    if (!rw_q) begin
                        rsp_data_d  = BusData;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    clk_d = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        addr_d  = head_addr;
                        data_d  = head_data;
                        rw_d    = head_write;
                        state_d = SETUP;
                    end else begin
                        rw_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                rw_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered bus/response outputs; reset drops any transaction in flight
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            clk_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw_q        <= rw_d;
            clk_q       <= clk_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign BusAddress   = addr_q;
    assign BusReadWrite = rw_q;
    assign BusClock     = clk_q;
    assign BusData      = rw_q ? data_q : {DATA_W{1'bz}};
    assign ctl.RspValid = rsp_valid_q;
    assign ctl.RspData  = rsp_data_q;
    assign ctl.Busy     = !empty || (state_q != IDLE);
endmodule
